// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - redirect, icache and decode signals of the fetch stage
interface fetch_ctrl_if;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         icache_req;
  logic [31:0]  icache_addr;
  logic         icache_ready;
  logic         icache_rvalid;
  logic [127:0] icache_rdata;
  logic         fetch_valid;
  logic [31:0]  fetch_pc;
  logic [127:0] fetch_inst;
  logic [3:0]   fetch_mask;
  logic         decode_ready;

  modport master (
    input  redirect_valid, redirect_pc, icache_ready, icache_rvalid, icache_rdata, decode_ready,
    output icache_req, icache_addr, fetch_valid, fetch_pc, fetch_inst, fetch_mask
  );

  modport slave (
    output redirect_valid, redirect_pc, icache_ready, icache_rvalid, icache_rdata, decode_ready,
    input  icache_req, icache_addr, fetch_valid, fetch_pc, fetch_inst, fetch_mask
  );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - 4-wide fetch sequencer: one outstanding icache line request,
// registered group to decode, back-pressure and redirect handling
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          FETCH_WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);
  localparam logic [31:0] LINE_BYTES = 32'(FETCH_WIDTH * 4);
  localparam logic [31:0] LINE_MASK  = ~(LINE_BYTES - 32'd1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t       state, state_next;
  logic [31:0]  pc, pc_next;
  logic [31:0]  pc_line;
  logic         valid_q, valid_next;
  logic         load_group;
  logic         accepted;
  logic [31:0]  grp_pc;
  logic [127:0] grp_inst;
  logic [3:0]   grp_mask;

  assign pc_line         = pc & LINE_MASK;
  assign bus.icache_req  = (state == S_REQ) && !rst;
  assign bus.icache_addr = pc_line;
  assign accepted        = bus.icache_req && bus.icache_ready;

  assign bus.fetch_valid = valid_q;
  assign bus.fetch_pc    = grp_pc;
  assign bus.fetch_inst  = grp_inst;
  assign bus.fetch_mask  = grp_mask;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = valid_q;
    load_group = 1'b0;
    case (state)
      S_REQ: begin
        // A request accepted in the redirect cycle still owes a response that must be eaten.
        if (accepted) state_next = bus.redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (bus.icache_rvalid) begin
          if (bus.redirect_valid) begin
            state_next = S_REQ;
          end else begin
            load_group = 1'b1;
            valid_next = 1'b1;
            pc_next    = pc_line + LINE_BYTES;
            state_next = S_HOLD;
          end
        end else if (bus.redirect_valid) begin
          state_next = S_DROP;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid || bus.decode_ready) begin
          valid_next = 1'b0;
          state_next = S_REQ;
        end
      end
      S_DROP: begin
        if (bus.icache_rvalid) state_next = S_REQ;
      end
      default: state_next = S_REQ;
    endcase
    if (bus.redirect_valid) pc_next = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      valid_q  <= 1'b0;
      grp_pc   <= 32'd0;
      grp_inst <= 128'd0;
      grp_mask <= 4'd0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      valid_q <= valid_next;
      if (load_group) begin
        grp_pc   <= pc_line;
        grp_inst <= bus.icache_rdata;
        grp_mask <= 4'b1111 << pc[3:2];
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized checks of fetch_ctrl against a
// transaction-level model of the fetch PC, outstanding request and presented group
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(RESET_PC), .FETCH_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic        d_rst = 1'b1, d_ready = 1'b0, d_dready = 1'b0, d_redir = 1'b0;
  logic [31:0] d_redir_pc = 32'd0;
  int          resp_lat = 1;

  bit           resp_pending = 0;
  int           resp_cnt = 0;
  logic [127:0] resp_data = 128'd0;

  logic [31:0]  m_pc;
  bit           m_out, m_stale, e_valid;
  logic [31:0]  e_pc;
  logic [127:0] e_inst;
  logic [3:0]   e_mask;

  function automatic logic [31:0] line_of(logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_out = 0; m_stale = 0;
    e_valid = 0; e_pc = 32'd0; e_inst = 128'd0; e_mask = 4'd0;
    resp_pending = 0;
  endtask

  // Model: pc advances one line per delivered group, any redirect replaces it and
  // poisons the response in flight; a group stays until decode takes it or a redirect.
  task automatic model_update();
    logic [31:0] old_pc;
    bit acc;
    if (rst) begin
      model_reset();
      return;
    end
    acc    = bus.icache_req && bus.icache_ready;
    old_pc = m_pc;
    if (bus.icache_rvalid && m_out) begin
      m_out = 0;
      if (!m_stale && !bus.redirect_valid) begin
        e_valid = 1;
        e_pc    = line_of(old_pc);
        e_inst  = bus.icache_rdata;
        e_mask  = 4'b1111 << old_pc[3:2];
        m_pc    = line_of(old_pc) + 32'd16;
      end
    end else if (e_valid && (bus.decode_ready || bus.redirect_valid)) begin
      e_valid = 0;
    end
    if (acc) begin
      m_out        = 1;
      m_stale      = bus.redirect_valid;
      resp_pending = 1;
      resp_cnt     = resp_lat;
      resp_data    = {$urandom, $urandom, $urandom, $urandom};
    end
    if (bus.redirect_valid) begin
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      if (m_out) m_stale = 1;
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !rst && !m_out && !e_valid;
    chk("icache_req", bus.icache_req, exp_req);
    if (exp_req) chk("icache_addr", bus.icache_addr, line_of(m_pc));
    chk("fetch_valid", bus.fetch_valid, e_valid);
    chk("fetch_pc", bus.fetch_pc, e_pc);
    chk("fetch_inst", bus.fetch_inst, e_inst);
    chk("fetch_mask", bus.fetch_mask, e_mask);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = d_rst;
    bus.icache_rvalid = 1'b0;
    bus.icache_rdata  = {$urandom, $urandom, $urandom, $urandom};
    if (resp_pending) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        bus.icache_rvalid = 1'b1;
        bus.icache_rdata  = resp_data;
        resp_pending      = 0;
      end
    end
    bus.icache_ready   = d_ready;
    bus.decode_ready   = d_dready;
    bus.redirect_valid = d_redir;
    bus.redirect_pc    = d_redir_pc;
    @(negedge clk);
    compare();
    model_update();
  endtask

  initial begin
    int n;
    bit ok;
    logic [31:0]  s_pc, s_addr;
    logic [127:0] s_inst;
    logic [3:0]   s_mask;

    bus.icache_rvalid = 1'b0; bus.icache_rdata = 128'd0; bus.icache_ready = 1'b0;
    bus.decode_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0;
    model_reset();

    d_rst = 1; step(); step();
    chk("rst_req", bus.icache_req, 1'b0);
    chk("rst_valid", bus.fetch_valid, 1'b0);
    chk("rst_mask", bus.fetch_mask, 4'd0);
    chk("rst_inst", bus.fetch_inst, 128'd0);
    chk("rst_pc", bus.fetch_pc, 32'd0);

    d_rst = 0; d_ready = 1; resp_lat = 1; step();
    chk("first_req", bus.icache_req, 1'b1);
    chk("first_addr", bus.icache_addr, 32'hBFC0_0000);
    step();
    chk("wait_not_valid", bus.fetch_valid, 1'b0);
    step();
    chk("first_valid_lat2", bus.fetch_valid, 1'b1);
    chk("first_mask", bus.fetch_mask, 4'b1111);
    chk("first_pc", bus.fetch_pc, 32'hBFC0_0000);

    s_pc = bus.fetch_pc; s_inst = bus.fetch_inst; s_mask = bus.fetch_mask; ok = 1;
    repeat (10) begin
      step();
      if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== s_pc || bus.fetch_inst !== s_inst ||
          bus.fetch_mask !== s_mask || bus.icache_req !== 1'b0) ok = 0;
    end
    chk("hold_stable", ok, 1'b1);

    d_dready = 1; step(); d_dready = 0; step();
    chk("next_req", bus.icache_req, 1'b1);
    chk("next_addr", bus.icache_addr, 32'hBFC0_0010);
    step(); step();
    chk("second_valid", bus.fetch_valid, 1'b1);

    d_redir = 1; d_redir_pc = 32'h8000_0008; d_dready = 1; step();
    d_redir = 0; d_dready = 0; step();
    chk("redir_drop", bus.fetch_valid, 1'b0);
    chk("redir_req", bus.icache_req, 1'b1);
    chk("redir_addr", bus.icache_addr, 32'h8000_0000);
    step(); step();
    chk("redir_mask", bus.fetch_mask, 4'b1100);
    chk("redir_pc", bus.fetch_pc, 32'h8000_0000);

    d_dready = 1; step(); d_dready = 0; resp_lat = 3; step();
    chk("pre_wait_addr", bus.icache_addr, 32'h8000_0010);
    d_redir = 1; d_redir_pc = 32'h0000_1234; step();
    d_redir = 0; d_ready = 0;
    n = 0; ok = 1;
    while (!bus.icache_req && n < 20) begin
      step(); n++;
      if (bus.fetch_valid) ok = 0;
    end
    chk("drop_no_group", ok, 1'b1);
    chk("drop_steps", n, 3);
    chk("drop_new_addr", bus.icache_addr, 32'h0000_1230);

    s_addr = bus.icache_addr; ok = 1;
    repeat (5) begin
      step();
      if (bus.icache_req !== 1'b1 || bus.icache_addr !== s_addr) ok = 0;
    end
    chk("stall_stable", ok, 1'b1);
    d_ready = 1; resp_lat = 1; step(); step(); step();
    chk("after_stall_valid", bus.fetch_valid, 1'b1);
    chk("after_stall_pc", bus.fetch_pc, 32'h0000_1230);
    chk("after_stall_mask", bus.fetch_mask, 4'b1110);

    d_redir = 1; d_redir_pc = 32'hFFFF_FFF4; step();
    d_redir = 0; step();
    chk("wrap_addr", bus.icache_addr, 32'hFFFF_FFF0);
    step(); step();
    chk("wrap_mask", bus.fetch_mask, 4'b1110);
    chk("wrap_pc", bus.fetch_pc, 32'hFFFF_FFF0);
    d_dready = 1; step(); d_dready = 0; step();
    chk("wrap_next_req", bus.icache_req, 1'b1);
    chk("wrap_next_addr", bus.icache_addr, 32'h0000_0000);

    for (int i = 0; i < 4000; i++) begin
      d_ready    = ($urandom_range(0, 3) != 0);
      d_dready   = $urandom_range(0, 1);
      d_redir    = ($urandom_range(0, 9) == 0);
      d_redir_pc = $urandom;
      if ($urandom_range(0, 7) == 0) d_redir_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      resp_lat   = $urandom_range(1, 4);
      d_rst      = (i >= 2000 && i < 2002);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
